// File: rtl/down_counter_4b_pkg.sv
// Shared definitions for the 4-bit synchronous down counter.
//   WIDTH_C        : counter width (only 4 is supported)
//   RELOAD_WRAP    : terminal action 0 -> 15
//   RELOAD_PRESET  : terminal action 0 -> D
//   slice_op_e     : per-bit operation selected inside one counter slice
package down_counter_4b_pkg;

  localparam int WIDTH_C       = 4;
  localparam int RELOAD_WRAP   = 0;
  localparam int RELOAD_PRESET = 1;

  typedef enum logic [1:0] {
    SLICE_HOLD   = 2'd0,
    SLICE_TOGGLE = 2'd1,
    SLICE_LOAD   = 2'd2
  } slice_op_e;

endpackage : down_counter_4b_pkg

// File: rtl/down_counter_bit.sv
// One slice of the down counter: a T flip-flop with asynchronous clear,
// synchronous parallel load and a toggle enable. Load beats toggle.
//   clk    : counter clock, rising edge
//   rst_n  : asynchronous active-low clear, forces q to 0
//   load   : synchronous load of d
//   d      : preset bit
//   toggle : invert q on the next rising edge
//   q      : stored bit
module down_counter_bit
  import down_counter_4b_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic d,
  input  logic toggle,
  output logic q
);

  slice_op_e op;

  always_comb begin
    if (load)        op = SLICE_LOAD;
    else if (toggle) op = SLICE_TOGGLE;
    else             op = SLICE_HOLD;
  end

  // NOTE: sequential state is assigned with <= so every slice samples the
  // same pre-edge values; blocking here would make bits depend on eval order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case (op)
        SLICE_LOAD:   q <= d;
        SLICE_TOGGLE: q <= ~q;
        default:      q <= q;
      endcase
    end
  end

endmodule : down_counter_bit

// File: rtl/down_counter_4b.sv
// 4-bit synchronous down counter with parallel load, two count enables,
// combinational borrow-out for cascading and a registered terminal-count
// pulse.
//   CLK   : clock, rising edge
//   nCLR  : asynchronous active-low clear (Q = 0, TC = 0)
//   nLOAD : synchronous active-low load of D (highest priority)
//   D     : preset value
//   ENP   : parallel (local) count enable
//   ENT   : trickle (cascade) count enable, also gates nBO
//   Q     : current count
//   nBO   : active-low borrow out, low when ENT = 1 and Q = 0
//   TC    : one-cycle pulse on the edge after a count step that reached 0
module down_counter_4b
  import down_counter_4b_pkg::*;
#(
  parameter int WIDTH  = WIDTH_C,
  parameter int RELOAD = RELOAD_WRAP
) (
  input  logic             CLK,
  input  logic             nCLR,
  input  logic             nLOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             ENP,
  input  logic             ENT,
  output logic [WIDTH-1:0] Q,
  output logic             nBO,
  output logic             TC
);

  logic             count_en;
  logic             q_zero;
  logic             preset_wrap;
  logic             slice_load;
  logic             step_to_zero;
  logic             zero_step;
  logic             lower_zero;
  logic [WIDTH-1:0] toggle;

  assign count_en = nLOAD & ENP & ENT;
  assign q_zero   = (Q == '0);

  // In preset mode the step past zero is a load of D rather than a wrap.
  assign preset_wrap = count_en & q_zero & (RELOAD == RELOAD_PRESET);
  assign slice_load  = ~nLOAD | preset_wrap;

  // Down-count in T flip-flop form: bit n toggles when every lower bit is 0.
  // At Q = 0 all bits toggle, which is exactly the 0 -> 15 wrap.
  // NOTE: always_comb uses blocking assignments and gives lower_zero a value
  // before the loop reads it, so no latch is inferred.
  always_comb begin
    lower_zero = 1'b1;
    toggle     = '0;
    for (int n = 0; n < WIDTH; n++) begin
      toggle[n]  = count_en & ~preset_wrap & lower_zero;
      lower_zero = lower_zero & ~Q[n];
    end
  end

  for (genvar n = 0; n < WIDTH; n++) begin : g_bit
    down_counter_bit u_bit (
      .clk    (CLK),
      .rst_n  (nCLR),
      .load   (slice_load),
      .d      (D[n]),
      .toggle (toggle[n]),
      .q      (Q[n])
    );
  end

  // A count step lands on zero from Q = 1, or from Q = 0 when presetting D = 0.
  // Loads and holds never qualify, so they cannot raise TC.
  assign step_to_zero = count_en & (preset_wrap ? (D == '0) : (Q == WIDTH'(1)));

  // zero_step marks the edge that reached zero; TC follows one edge later.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      zero_step <= 1'b0;
      TC        <= 1'b0;
    end else begin
      zero_step <= step_to_zero;
      TC        <= zero_step;
    end
  end

  assign nBO = ~(ENT & q_zero);

endmodule : down_counter_4b

// File: tb/tb_down_counter_4b.sv
module tb_down_counter_4b;

  logic       clk = 1'b0;
  logic       nclr, nload, enp, ent;
  logic [3:0] d;
  logic [3:0] q_w, q_p;
  logic       nbo_w, nbo_p, tc_w, tc_p;

  // cascade pair
  logic       c_nload, c_enp, c_ent;
  logic [7:0] c_d;
  logic [3:0] lo_q, hi_q;
  logic       lo_nbo, hi_nbo, lo_tc, hi_tc;
  logic       hi_ent;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state: index 0 = wrap mode, 1 = preset mode
  logic [3:0] m_q  [2];
  logic       m_zs [2];
  logic       m_tc [2];
  logic [7:0] c_model;

  always #5 clk = ~clk;

  down_counter_4b #(.WIDTH(4), .RELOAD(0)) dut_wrap (
    .CLK(clk), .nCLR(nclr), .nLOAD(nload), .D(d), .ENP(enp), .ENT(ent),
    .Q(q_w), .nBO(nbo_w), .TC(tc_w));

  down_counter_4b #(.WIDTH(4), .RELOAD(1)) dut_pre (
    .CLK(clk), .nCLR(nclr), .nLOAD(nload), .D(d), .ENP(enp), .ENT(ent),
    .Q(q_p), .nBO(nbo_p), .TC(tc_p));

  assign hi_ent = ~lo_nbo;

  down_counter_4b #(.WIDTH(4), .RELOAD(0)) dut_lo (
    .CLK(clk), .nCLR(nclr), .nLOAD(c_nload), .D(c_d[3:0]), .ENP(c_enp), .ENT(c_ent),
    .Q(lo_q), .nBO(lo_nbo), .TC(lo_tc));

  down_counter_4b #(.WIDTH(4), .RELOAD(0)) dut_hi (
    .CLK(clk), .nCLR(nclr), .nLOAD(c_nload), .D(c_d[7:4]), .ENP(c_enp), .ENT(hi_ent),
    .Q(hi_q), .nBO(hi_nbo), .TC(hi_tc));

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 4'd0; m_zs[k] = 1'b0; m_tc[k] = 1'b0;
    end
  endtask

  // one rising edge, described by the counter's rules in plain arithmetic
  task automatic model_edge();
    logic [3:0] nq;
    for (int k = 0; k < 2; k++) begin
      if (!nclr) begin
        m_q[k] = 4'd0; m_zs[k] = 1'b0; m_tc[k] = 1'b0;
      end else begin
        m_tc[k] = m_zs[k];
        if (!nload) begin
          m_q[k] = d; m_zs[k] = 1'b0;
        end else if (enp && ent) begin
          if (m_q[k] == 4'd0) nq = (k == 1) ? d : 4'd15;
          else                nq = m_q[k] - 4'd1;
          m_zs[k] = (nq == 4'd0);
          m_q[k]  = nq;
        end else begin
          m_zs[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q_wrap"},   {4'h0, q_w}, {4'h0, m_q[0]});
    check({tag, ".tc_wrap"},  {7'h0, tc_w}, {7'h0, m_tc[0]});
    check({tag, ".nbo_wrap"}, {7'h0, nbo_w}, {7'h0, !(ent && m_q[0] == 4'd0)});
    check({tag, ".q_pre"},    {4'h0, q_p}, {4'h0, m_q[1]});
    check({tag, ".tc_pre"},   {7'h0, tc_p}, {7'h0, m_tc[1]});
    check({tag, ".nbo_pre"},  {7'h0, nbo_p}, {7'h0, !(ent && m_q[1] == 4'd0)});
  endtask

  // drive inputs, take one edge, compare on the falling edge
  task automatic cyc(input logic r_n, input logic ld_n, input logic [3:0] dv,
                     input logic p, input logic t, input string tag);
    nclr = r_n; nload = ld_n; d = dv; enp = p; ent = t;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic casc(input logic ld_n, input logic [7:0] dv, input logic en, input string tag);
    c_nload = ld_n; c_d = dv; c_enp = en; c_ent = en;
    @(posedge clk);
    if (!ld_n)  c_model = dv;
    else if (en) c_model = c_model - 8'd1;
    @(negedge clk);
    check(tag, {hi_q, lo_q}, c_model);
  endtask

  initial begin
    nclr = 1'b0; nload = 1'b1; d = 4'd0; enp = 1'b0; ent = 1'b0;
    c_nload = 1'b1; c_d = 8'h00; c_enp = 1'b0; c_ent = 1'b0; c_model = 8'h00;
    model_clear();

    // reset state
    #2;
    check("rst.q", {4'h0, q_w}, 8'h00);
    check("rst.tc", {7'h0, tc_w}, 8'h00);
    check("rst.nbo_ent0", {7'h0, nbo_w}, 8'h01);
    ent = 1'b1;
    #1;
    check("rst.nbo_ent1", {7'h0, nbo_w}, 8'h00);
    @(negedge clk);

    // load A with enables off, then count down to 0 and watch TC
    cyc(1, 0, 4'hA, 0, 0, "load_a");
    check("load_a.q", {4'h0, q_w}, 8'h0A);
    for (int i = 0; i < 10; i++) cyc(1, 1, 4'hA, 1, 1, "cnt_a");
    check("cnt_a.q_end", {4'h0, q_w}, 8'h00);
    check("cnt_a.tc_not_yet", {7'h0, tc_w}, 8'h00);
    cyc(1, 1, 4'hA, 1, 0, "tc_edge");
    check("tc_edge.tc", {7'h0, tc_w}, 8'h01);
    cyc(1, 1, 4'hA, 1, 0, "tc_hold");
    check("tc_hold.tc", {7'h0, tc_w}, 8'h00);

    // terminal action from 0: wrap vs preset
    cyc(1, 1, 4'd5, 1, 1, "term");
    check("term.wrap_q", {4'h0, q_w}, 8'h0F);
    check("term.wrap_tc", {7'h0, tc_w}, 8'h00);
    check("term.pre_q", {4'h0, q_p}, 8'h05);

    // hold on ENT = 0, nBO high
    cyc(1, 0, 4'd3, 1, 0, "ld3");
    cyc(1, 1, 4'd3, 1, 0, "hold3");
    check("hold3.q", {4'h0, q_w}, 8'h03);
    check("hold3.nbo", {7'h0, nbo_w}, 8'h01);

    // nBO follows ENT combinationally at Q = 0
    cyc(1, 0, 4'd0, 0, 0, "ld0");
    ent = 1'b1; #1;
    check("nbo_ent1", {7'h0, nbo_w}, 8'h00);
    ent = 1'b0; #1;
    check("nbo_ent0", {7'h0, nbo_w}, 8'h01);
    @(negedge clk);

    // load wins over count; load of 0 gives no TC
    cyc(1, 0, 4'd7, 1, 1, "ld_wins");
    check("ld_wins.q", {4'h0, q_w}, 8'h07);
    cyc(1, 0, 4'd0, 1, 1, "ld_zero");
    cyc(1, 1, 4'd0, 0, 0, "ld_zero_hold");
    check("ld_zero.tc", {7'h0, tc_w}, 8'h00);

    // asynchronous clear mid-cycle at Q = 9
    cyc(1, 0, 4'd9, 1, 1, "ld9");
    #2;
    ent = 1'b1; nclr = 1'b0;
    #1;
    model_clear();
    check("aclr.q", {4'h0, q_w}, 8'h00);
    check("aclr.tc", {7'h0, tc_w}, 8'h00);
    check("aclr.nbo", {7'h0, nbo_w}, 8'h00);
    @(negedge clk);
    cyc(0, 0, 4'd6, 1, 1, "clr_held");
    cyc(1, 0, 4'd6, 1, 1, "clr_release");
    check("clr_release.q", {4'h0, q_w}, 8'h06);

    // clear while TC is high
    cyc(1, 0, 4'd1, 0, 0, "ld1");
    cyc(1, 1, 4'd1, 1, 1, "cnt1");
    cyc(1, 1, 4'd1, 0, 0, "tc_up");
    check("tc_up.tc", {7'h0, tc_w}, 8'h01);
    #2; nclr = 1'b0; #1;
    model_clear();
    check("aclr_tc.tc", {7'h0, tc_w}, 8'h00);
    @(negedge clk);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) != 0),
          4'($urandom_range(0, 15)), ($urandom_range(0, 4) != 0),
          ($urandom_range(0, 4) != 0), "rnd");
    end

    // two-stage cascade counting as one 8-bit counter
    nclr = 1'b1; nload = 1'b1; enp = 1'b0; ent = 1'b0;
    casc(0, 8'h10, 0, "casc.load");
    casc(1, 8'h10, 1, "casc.cnt");
    check("casc.first", {hi_q, lo_q}, 8'h0F);
    for (int i = 0; i < 16; i++) casc(1, 8'h10, 1, "casc.cnt");
    check("casc.wrap", {hi_q, lo_q}, 8'hFF);
    for (int i = 0; i < 20; i++) casc(1, 8'h00, ($urandom_range(0, 3) != 0), "casc.rnd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_down_counter_4b
